// File: rtl/register_file_if.sv
// Register-file bus: write-back port, two ALU read ports and the debug display port.
interface register_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] DispReg;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] DispData;
  logic [7:0]        WriteCount;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DispReg,
    input  ReadData1, ReadData2, DispData, WriteCount
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DispReg,
    output ReadData1, ReadData2, DispData, WriteCount
  );
endinterface

// File: rtl/register_file.sv
// Multi-ported register file feeding the ALU: two combinational read ports with
// optional same-cycle write forwarding, one write port, registered debug display port.
module register_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  register_file_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_disp;
  logic [7:0]        r_wcnt;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // A write to the hardwired zero register is dropped entirely: no store, no count, no forward.
  assign w_wr_en = bus.RegWrite && !((ZERO_REG != 0) && (bus.WriteReg == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_disp <= '0;
      r_wcnt <= '0;
    end else begin
      r_disp <= r_regs[bus.DispReg];
      if (w_wr_en) begin
        r_regs[bus.WriteReg] <= bus.WriteData;
        if (r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'd1;
      end
    end
  end

  // Priority: reset forces zero, then forwarding, then the zero register, then storage.
  always_comb begin
    w_rd1 = r_regs[bus.ReadReg1];
    w_rd2 = r_regs[bus.ReadReg2];
    if ((ZERO_REG != 0) && (bus.ReadReg1 == '0)) w_rd1 = '0;
    if ((ZERO_REG != 0) && (bus.ReadReg2 == '0)) w_rd2 = '0;
    if ((BYPASS != 0) && w_wr_en && (bus.WriteReg == bus.ReadReg1)) w_rd1 = bus.WriteData;
    if ((BYPASS != 0) && w_wr_en && (bus.WriteReg == bus.ReadReg2)) w_rd2 = bus.WriteData;
    if (reset) begin
      w_rd1 = '0;
      w_rd2 = '0;
    end
  end

  assign bus.ReadData1  = w_rd1;
  assign bus.ReadData2  = w_rd2;
  assign bus.DispData   = r_disp;
  assign bus.WriteCount = r_wcnt;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three parameterisations driven by one stimulus stream,
// checked every cycle against an array model plus hand-computed expectations.
`timescale 1ns/100ps
module tb_register_file;
  logic       clk;
  logic       rst;
  logic       t_we;
  logic [1:0] t_wr;
  logic [7:0] t_wd;
  logic [1:0] t_r1;
  logic [1:0] t_r2;
  logic [1:0] t_dr;

  int errors;
  int checks;

  // k=0: ZERO_REG=0 BYPASS=1, k=1: ZERO_REG=0 BYPASS=0, k=2: ZERO_REG=1 BYPASS=1
  register_file_if #(.DATA_W(8), .ADDR_W(2)) if_a ();
  register_file_if #(.DATA_W(8), .ADDR_W(2)) if_b ();
  register_file_if #(.DATA_W(8), .ADDR_W(2)) if_c ();

  register_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_a (.clk(clk), .reset(rst), .bus(if_a));
  register_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) u_b (.clk(clk), .reset(rst), .bus(if_b));
  register_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u_c (.clk(clk), .reset(rst), .bus(if_c));

  assign if_a.RegWrite = t_we; assign if_a.WriteReg = t_wr; assign if_a.WriteData = t_wd;
  assign if_a.ReadReg1 = t_r1; assign if_a.ReadReg2 = t_r2; assign if_a.DispReg   = t_dr;
  assign if_b.RegWrite = t_we; assign if_b.WriteReg = t_wr; assign if_b.WriteData = t_wd;
  assign if_b.ReadReg1 = t_r1; assign if_b.ReadReg2 = t_r2; assign if_b.DispReg   = t_dr;
  assign if_c.RegWrite = t_we; assign if_c.WriteReg = t_wr; assign if_c.WriteData = t_wd;
  assign if_c.ReadReg1 = t_r1; assign if_c.ReadReg2 = t_r2; assign if_c.DispReg   = t_dr;

  logic [7:0] o_rd1 [3];
  logic [7:0] o_rd2 [3];
  logic [7:0] o_disp[3];
  logic [7:0] o_cnt [3];
  assign o_rd1[0] = if_a.ReadData1; assign o_rd2[0] = if_a.ReadData2;
  assign o_disp[0] = if_a.DispData; assign o_cnt[0] = if_a.WriteCount;
  assign o_rd1[1] = if_b.ReadData1; assign o_rd2[1] = if_b.ReadData2;
  assign o_disp[1] = if_b.DispData; assign o_cnt[1] = if_b.WriteCount;
  assign o_rd1[2] = if_c.ReadData1; assign o_rd2[2] = if_c.ReadData2;
  assign o_disp[2] = if_c.DispData; assign o_cnt[2] = if_c.WriteCount;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [3][4];
  logic [7:0] m_disp [3];
  int         m_cnt  [3];

  function automatic bit zr(int k);
    return (k == 2);
  endfunction

  function automatic bit byp(int k);
    return (k != 1);
  endfunction

  function automatic bit commits(int k);
    return t_we && !(zr(k) && t_wr == 2'd0);
  endfunction

  function automatic logic [7:0] exp_rd(int k, logic [1:0] idx);
    if (rst) return 8'h00;
    if (byp(k) && commits(k) && t_wr == idx) return t_wd;
    if (zr(k) && idx == 2'd0) return 8'h00;
    return m_regs[k][idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int j = 0; j < 4; j++) m_regs[k][j] = 8'h00;
        m_disp[k] = 8'h00;
        m_cnt[k]  = 0;
      end else begin
        m_disp[k] = m_regs[k][t_dr];
        if (commits(k)) begin
          m_regs[k][t_wr] = t_wd;
          if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, all outputs of all three instances.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd1[%0d]", k), o_rd1[k], exp_rd(k, t_r1));
      chk($sformatf("rd2[%0d]", k), o_rd2[k], exp_rd(k, t_r2));
      chk($sformatf("disp[%0d]", k), o_disp[k], m_disp[k]);
      chk($sformatf("cnt[%0d]", k), o_cnt[k], m_cnt[k][7:0]);
    end
  end

  task automatic set_in(input logic we, input logic [1:0] wr, input logic [7:0] wd,
                        input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] dr);
    t_we = we; t_wr = wr; t_wd = wd; t_r1 = r1; t_r2 = r2; t_dr = dr;
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    set_in(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0);
    step(); step();
    rst = 1'b0;

    // Reset while r2 holds A5: read port must clear immediately
    set_in(1'b1, 2'd2, 8'hA5, 2'd2, 2'd2, 2'd2);
    step();
    set_in(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 2'd2);
    #1 chk("pre_reset_r2", o_rd1[0], 8'hA5);
    chk("pre_reset_cnt", o_cnt[0], 8'd1);
    #1 rst = 1'b1;
    #1 chk("reset_rd1", o_rd1[0], 8'h00);
    chk("reset_cnt", o_cnt[0], 8'h00);
    chk("reset_disp", o_disp[0], 8'h00);
    // A write coinciding with reset is lost
    set_in(1'b1, 2'd1, 8'h77, 2'd1, 2'd1, 2'd1);
    #1 chk("reset_no_bypass", o_rd1[0], 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    set_in(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1);
    #1 chk("reset_write_lost", o_rd1[0], 8'h00);
    #1;

    // Basic write/read
    set_in(1'b1, 2'd1, 8'h3C, 2'd0, 2'd0, 2'd0);
    step();
    set_in(1'b1, 2'd3, 8'hF0, 2'd0, 2'd0, 2'd0);
    step();
    set_in(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 2'd0);
    #1 chk("basic_rd1", o_rd1[0], 8'h3C);
    chk("basic_rd2", o_rd2[0], 8'hF0);
    chk("basic_cnt", o_cnt[0], 8'd2);
    #1;

    // Bypass on (a) versus off (b)
    set_in(1'b1, 2'd2, 8'h11, 2'd0, 2'd0, 2'd0);
    step();
    set_in(1'b1, 2'd2, 8'h7E, 2'd2, 2'd2, 2'd0);
    #1 chk("byp_on_rd1", o_rd1[0], 8'h7E);
    chk("byp_on_rd2", o_rd2[0], 8'h7E);
    chk("byp_off_rd1", o_rd1[1], 8'h11);
    chk("byp_off_rd2", o_rd2[1], 8'h11);
    #1 step();
    set_in(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 2'd0);
    #1 chk("byp_off_after_rd1", o_rd1[1], 8'h7E);
    chk("byp_off_after_rd2", o_rd2[1], 8'h7E);
    #1;

    // Zero register
    set_in(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 2'd0);
    #1 chk("zr_no_bypass", o_rd1[2], 8'h00);
    chk("nozr_bypass", o_rd1[0], 8'hFF);
    #1 step();
    set_in(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0);
    #1 chk("zr_rd1", o_rd1[2], 8'h00);
    chk("zr_cnt", o_cnt[2], 8'd4);
    chk("nozr_cnt", o_cnt[0], 8'd5);
    chk("nozr_r0", o_rd1[0], 8'hFF);
    #1;

    // Display latency
    set_in(1'b1, 2'd3, 8'h5A, 2'd0, 2'd0, 2'd3);
    step();
    set_in(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd3);
    #1 chk("disp_old", o_disp[0], 8'hF0);
    #1 step();
    #1 chk("disp_new", o_disp[0], 8'h5A);
    #1;

    // Saturation: 300 writes to r1
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, 2'd1, i[7:0], 2'd0, 2'd0, 2'd0);
      step();
    end
    set_in(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 2'd1);
    #1 chk("sat_cnt", o_cnt[0], 8'd255);
    chk("sat_cnt_zr", o_cnt[2], 8'd255);
    chk("sat_r1", o_rd1[0], 8'h2B);
    #1 step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
